// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: one-bus arbiter for dbg > lsu > ifu, ifu anti-starvation,   |
// | pipeline hold and hung-bus timeout.               Revision: 1.0          |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_100MHz,
  input  logic                arst_n,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_ack_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_ack_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [ADDR_W-1:0]   dbg_addr_i,
  input  logic [DATA_W-1:0]   dbg_wdata_i,
  output logic                dbg_ack_o,
  output logic [DATA_W-1:0]   dbg_rdata_o,
  output logic                m_req_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_ack_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  output logic                hold_o,
  output logic                err_o
);
  localparam int BE_W = DATA_W / 8;
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  localparam logic [TO_W-1:0] C_TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0] C_ST_LIMIT = ST_W'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IFU = 2'd1, OWN_LSU = 2'd2, OWN_DBG = 2'd3} owner_t;

  state_t r_state, w_state_nxt;
  owner_t r_owner, w_grant;
  logic [ST_W-1:0]   r_starve;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_err, w_timeout;
  logic              r_we, w_we;
  logic [BE_W-1:0]   r_be, w_be;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata, w_cap;
  logic [DATA_W-1:0] r_ifu_rdata, r_lsu_rdata, r_dbg_rdata;

  // A starved ifu overrides the fixed priority for exactly one grant.
  always_comb begin
    w_grant = OWN_NONE;
    if (ifu_req_i && (r_starve == C_ST_LIMIT)) w_grant = OWN_IFU;
    else if (dbg_req_i)                        w_grant = OWN_DBG;
    else if (lsu_req_i)                        w_grant = OWN_LSU;
    else if (ifu_req_i)                        w_grant = OWN_IFU;
  end

  always_comb begin
    w_we    = 1'b0;
    w_be    = '1;
    w_addr  = ifu_addr_i;
    w_wdata = '0;
    case (w_grant)
      OWN_DBG: begin
        w_we    = dbg_we_i;
        w_addr  = dbg_addr_i;
        w_wdata = dbg_wdata_i;
      end
      OWN_LSU: begin
        w_we    = lsu_we_i;
        w_be    = lsu_be_i;
        w_addr  = lsu_addr_i;
        w_wdata = lsu_wdata_i;
      end
      default: ;
    endcase
  end

  // An ack in the final wait cycle takes precedence over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (w_grant != OWN_NONE) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (m_ack_i) begin
          w_state_nxt = S_RESP;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_state_nxt = S_RESP;
          w_timeout   = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_cap = m_ack_i ? m_rdata_i : '0;

  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_starve    <= '0;
      r_to_cnt    <= '0;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_timeout;
      case (r_state)
        S_IDLE: begin
          if (w_grant != OWN_NONE) begin
            r_owner <= w_grant;
            r_we    <= w_we;
            r_be    <= w_be;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            if (w_grant == OWN_IFU) r_starve <= '0;
            else if (ifu_req_i)     r_starve <= r_starve + ST_W'(1);
          end
        end
        S_WAIT: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          if (w_state_nxt == S_RESP) begin
            case (r_owner)
              OWN_IFU: r_ifu_rdata <= w_cap;
              OWN_LSU: r_lsu_rdata <= w_cap;
              OWN_DBG: r_dbg_rdata <= w_cap;
              default: ;
            endcase
          end
        end
        S_RESP:  r_to_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign m_req_o     = (r_state == S_WAIT);
  assign m_we_o      = r_we;
  assign m_be_o      = r_be;
  assign m_addr_o    = r_addr;
  assign m_wdata_o   = r_wdata;
  assign err_o       = r_err;
  assign ifu_ack_o   = (r_state == S_RESP) && (r_owner == OWN_IFU);
  assign lsu_ack_o   = (r_state == S_RESP) && (r_owner == OWN_LSU);
  assign dbg_ack_o   = (r_state == S_RESP) && (r_owner == OWN_DBG);
  assign ifu_rdata_o = r_ifu_rdata;
  assign lsu_rdata_o = r_lsu_rdata;
  assign dbg_rdata_o = r_dbg_rdata;
  assign hold_o      = (lsu_req_i & ~lsu_ack_o) | (dbg_req_i & ~dbg_ack_o);
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed timing cases plus random three-master traffic
// checked by a scoreboard against a memory/arbitration reference model.
module tb_mem_arbiter;
  logic        clk_100MHz = 1'b0;
  logic        arst_n;
  logic        ifu_req_i, lsu_req_i, lsu_we_i, dbg_req_i, dbg_we_i, m_ack_i;
  logic [31:0] ifu_addr_i, lsu_addr_i, lsu_wdata_i, dbg_addr_i, dbg_wdata_i, m_rdata_i;
  logic [3:0]  lsu_be_i;
  logic        ifu_ack_o, lsu_ack_o, dbg_ack_o, m_req_o, m_we_o, hold_o, err_o;
  logic [31:0] ifu_rdata_o, lsu_rdata_o, dbg_rdata_o, m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;

  mem_arbiter dut (
    .clk_100MHz(clk_100MHz), .arst_n(arst_n),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_ack_o(ifu_ack_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_ack_o(lsu_ack_o), .lsu_rdata_o(lsu_rdata_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i), .hold_o(hold_o), .err_o(err_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct packed { logic wr; logic [31:0] data; } exp_t;

  int vectors = 0, miscompares = 0, cycle = 0;
  int slave_mode = 0;   // 0 bench drives bus, 1 random wait, 2 fixed wait, 3 never ack
  int slave_fixed = 0, s_left = 0, model_starve = 0;
  logic s_active = 1'b0, mon_en = 1'b0, prev_mreq = 1'b0;
  logic [2:0] reqs_at_edge = 3'b000;
  logic [31:0] mem_slave [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  exp_t q_ifu[$], q_lsu[$], q_dbg[$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return mem_slave.exists(a) ? mem_slave[a] : init_val(a);
  endfunction
  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk_100MHz) begin
    cycle++;
    reqs_at_edge = {dbg_req_i, lsu_req_i, ifu_req_i};
  end

  // Bus slave model.
  always @(negedge clk_100MHz) begin
    if (slave_mode != 0) begin
      m_ack_i = 1'b0;
      m_rdata_i = 32'h0;
      if (!m_req_o) s_active = 1'b0;
      else if (slave_mode != 3) begin
        if (!s_active) begin
          s_active = 1'b1;
          s_left = (slave_mode == 1) ? int'($urandom_range(0, 3)) : slave_fixed;
        end
        if (s_left == 0) begin
          m_ack_i = 1'b1;
          m_rdata_i = slave_rd(m_addr_o);
          if (m_we_o) mem_slave[m_addr_o] = merge(slave_rd(m_addr_o), m_wdata_o, m_be_o);
          s_active = 1'b0;
        end else s_left--;
      end
    end
  end

  // Scoreboard monitor: grant decisions, latched fields and responses.
  always @(negedge clk_100MHz) begin
    exp_t e;
    int exp_g;
    if (!arst_n) model_starve = 0;
    if (mon_en) begin
      if (m_req_o && !prev_mreq) begin
        if (reqs_at_edge[0] && model_starve == 4) exp_g = 1;
        else if (reqs_at_edge[2]) exp_g = 3;
        else if (reqs_at_edge[1]) exp_g = 2;
        else exp_g = 1;
        check("grant_owner", {30'd0, m_addr_o[29:28]}, 32'(exp_g));
        if (exp_g == 1) model_starve = 0;
        else if (reqs_at_edge[0]) model_starve++;
        case (exp_g)
          1: begin check("grant_addr_ifu", m_addr_o, ifu_addr_i); check("grant_we_ifu", 32'(m_we_o), 32'd0); end
          2: begin
            check("grant_addr_lsu", m_addr_o, lsu_addr_i); check("grant_we_lsu", 32'(m_we_o), 32'(lsu_we_i));
            if (lsu_we_i) begin check("grant_be_lsu", 32'(m_be_o), 32'(lsu_be_i)); check("grant_wdata_lsu", m_wdata_o, lsu_wdata_i); end
          end
          default: begin
            check("grant_addr_dbg", m_addr_o, dbg_addr_i); check("grant_we_dbg", 32'(m_we_o), 32'(dbg_we_i));
            if (dbg_we_i) begin check("grant_be_dbg", 32'(m_be_o), 32'hF); check("grant_wdata_dbg", m_wdata_o, dbg_wdata_i); end
          end
        endcase
      end
      if (ifu_ack_o) begin
        if (q_ifu.size() == 0) check("ifu_unexpected_ack", 32'd1, 32'd0);
        else begin e = q_ifu.pop_front(); check("ifu_rdata", ifu_rdata_o, e.data); end
        check("ifu_err", 32'(err_o), 32'd0);
      end
      if (lsu_ack_o) begin
        if (q_lsu.size() == 0) check("lsu_unexpected_ack", 32'd1, 32'd0);
        else begin e = q_lsu.pop_front(); if (!e.wr) check("lsu_rdata", lsu_rdata_o, e.data); end
        check("lsu_err", 32'(err_o), 32'd0);
      end
      if (dbg_ack_o) begin
        if (q_dbg.size() == 0) check("dbg_unexpected_ack", 32'd1, 32'd0);
        else begin e = q_dbg.pop_front(); if (!e.wr) check("dbg_rdata", dbg_rdata_o, e.data); end
        check("dbg_err", 32'(err_o), 32'd0);
      end
    end
    prev_mreq = m_req_o;
  end

  task automatic wait_ack(input int who, input int bound, output int cyc, output logic got);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < bound) begin
      @(negedge clk_100MHz); #1;
      cyc++;
      got = (who == 1) ? ifu_ack_o : (who == 2) ? lsu_ack_o : dbg_ack_o;
    end
    if (!got) check("ack_wait_expired", 32'(who), 32'hFFFF_FFFF);
  endtask

  // Random master: who 1=ifu, 2=lsu, 3=dbg; each uses its own address region.
  task automatic run_master(input int who, input int n);
    logic [31:0] a, wd;
    logic wr;
    logic [3:0] be;
    int cyc;
    logic got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_100MHz);
      a  = (32'(who) << 28) | (32'($urandom_range(0, 7)) << 2);
      wr = (who != 1) && ($urandom_range(0, 1) == 1);
      be = (who == 2) ? 4'($urandom_range(1, 15)) : 4'hF;
      wd = $urandom;
      if (wr) shadow[a] = merge(shadow_rd(a), wd, be);
      case (who)
        1: begin q_ifu.push_back('{wr, shadow_rd(a)}); ifu_addr_i = a; ifu_req_i = 1'b1; end
        2: begin
          q_lsu.push_back('{wr, shadow_rd(a)});
          lsu_addr_i = a; lsu_we_i = wr; lsu_be_i = be; lsu_wdata_i = wd; lsu_req_i = 1'b1;
        end
        default: begin
          q_dbg.push_back('{wr, shadow_rd(a)});
          dbg_addr_i = a; dbg_we_i = wr; dbg_wdata_i = wd; dbg_req_i = 1'b1;
        end
      endcase
      wait_ack(who, 300, cyc, got);
      case (who)
        1: ifu_req_i = 1'b0;
        2: lsu_req_i = 1'b0;
        default: dbg_req_i = 1'b0;
      endcase
      if (!got) break;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    slave_mode = 0; mon_en = 1'b0; arst_n = 1'b0;
    ifu_req_i = 0; lsu_req_i = 0; dbg_req_i = 0; m_ack_i = 0; m_rdata_i = 0;
    repeat (2) @(negedge clk_100MHz);
    arst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start, cyc, n_req, t_dbg, t_lsu, t_ifu, k, g;
    logic got;
    arst_n = 0; ifu_req_i = 0; lsu_req_i = 0; dbg_req_i = 0; lsu_we_i = 0; dbg_we_i = 0;
    ifu_addr_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    lsu_be_i = 0; m_ack_i = 0; m_rdata_i = 0;

    // Reset state.
    do_reset();
    #1;
    check("rst_m_req", 32'(m_req_o), 0); check("rst_acks", {29'd0, ifu_ack_o, lsu_ack_o, dbg_ack_o}, 0);
    check("rst_err", 32'(err_o), 0); check("rst_hold", 32'(hold_o), 0);
    check("rst_m_addr", m_addr_o, 0); check("rst_lsu_rdata", lsu_rdata_o, 0);

    // Single lsu load with a zero-wait slave.
    slave_mode = 2; slave_fixed = 0; mem_slave[32'h100] = 32'hDEAD_BEEF;
    @(negedge clk_100MHz);
    lsu_addr_i = 32'h100; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_req_i = 1; #1;
    check("t1_hold_n", 32'(hold_o), 1); check("t1_mreq_n", 32'(m_req_o), 0);
    @(negedge clk_100MHz); #1;
    check("t1_mreq_n1", 32'(m_req_o), 1); check("t1_ack_n1", 32'(lsu_ack_o), 0); check("t1_hold_n1", 32'(hold_o), 1);
    @(negedge clk_100MHz); #1;
    check("t1_ack_n2", 32'(lsu_ack_o), 1); check("t1_rdata", lsu_rdata_o, 32'hDEAD_BEEF);
    check("t1_mreq_n2", 32'(m_req_o), 0); check("t1_hold_n2", 32'(hold_o), 0); check("t1_err", 32'(err_o), 0);
    lsu_req_i = 0;
    @(negedge clk_100MHz); #1;
    check("t1_ack_n3", 32'(lsu_ack_o), 0); check("t1_rdata_hold", lsu_rdata_o, 32'hDEAD_BEEF);

    // All three masters request together.
    do_reset(); slave_mode = 2; slave_fixed = 0;
    @(negedge clk_100MHz);
    dbg_addr_i = 32'h3000_0010; dbg_we_i = 0; lsu_addr_i = 32'h2000_0010; lsu_we_i = 0;
    ifu_addr_i = 32'h1000_0010;
    dbg_req_i = 1; lsu_req_i = 1; ifu_req_i = 1;
    start = cycle; t_dbg = -1; t_lsu = -1; t_ifu = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk_100MHz); #1;
      if (dbg_ack_o) begin t_dbg = cycle - start; dbg_req_i = 0; end
      if (lsu_ack_o) begin t_lsu = cycle - start; lsu_req_i = 0; end
      if (ifu_ack_o) begin t_ifu = cycle - start; ifu_req_i = 0; check("t2_ifu_rdata", ifu_rdata_o, init_val(32'h1000_0010)); end
    end
    check("t2_dbg_ack_cycle", 32'(t_dbg), 2); check("t2_lsu_ack_cycle", 32'(t_lsu), 5);
    check("t2_ifu_ack_cycle", 32'(t_ifu), 8);
    check("t2_dbg_rdata", dbg_rdata_o, init_val(32'h3000_0010));

    // Continuous lsu traffic with ifu pending: ifu every fifth grant.
    do_reset(); slave_mode = 2; slave_fixed = 0;
    @(negedge clk_100MHz);
    lsu_addr_i = 32'h2000_0020; lsu_we_i = 0; ifu_addr_i = 32'h1000_0020;
    lsu_req_i = 1; ifu_req_i = 1;
    k = 0; cyc = 0;
    while (k < 10 && cyc < 100) begin
      @(negedge clk_100MHz); #1;
      cyc++;
      if (lsu_ack_o || ifu_ack_o) begin
        g = ifu_ack_o ? 1 : 2;
        check($sformatf("t3_grant%0d", k), 32'(g), (k % 5 == 4) ? 32'd1 : 32'd2);
        k++;
      end
    end
    check("t3_grant_count", 32'(k), 10);
    lsu_req_i = 0; ifu_req_i = 0;

    // Ack on the very last wait cycle beats the timeout; then a hung slave.
    do_reset(); slave_mode = 2; slave_fixed = 254;
    @(negedge clk_100MHz);
    ifu_addr_i = 32'h1000_0040; ifu_req_i = 1;
    n_req = 0; got = 0; cyc = 0;
    while (!got && cyc < 400) begin
      @(negedge clk_100MHz); #1;
      cyc++;
      if (m_req_o) n_req++;
      got = ifu_ack_o;
    end
    check("t4_edge_wait_cycles", 32'(n_req), 255); check("t4_edge_ack", 32'(got), 1);
    check("t4_edge_err", 32'(err_o), 0); check("t4_edge_rdata", ifu_rdata_o, init_val(32'h1000_0040));
    ifu_req_i = 0;
    slave_mode = 3;
    @(negedge clk_100MHz);
    ifu_addr_i = 32'h1000_0044; ifu_req_i = 1;
    n_req = 0; got = 0; cyc = 0;
    while (!got && cyc < 400) begin
      @(negedge clk_100MHz); #1;
      cyc++;
      if (m_req_o) n_req++;
      got = ifu_ack_o;
    end
    check("t4_to_wait_cycles", 32'(n_req), 255); check("t4_to_ack", 32'(got), 1);
    check("t4_to_rdata", ifu_rdata_o, 0); check("t4_to_err", 32'(err_o), 1);
    check("t4_to_mreq", 32'(m_req_o), 0);
    ifu_req_i = 0;
    @(negedge clk_100MHz); #1;
    check("t4_post_err", 32'(err_o), 0); check("t4_post_mreq", 32'(m_req_o), 0);

    // Byte-masked store held through a 3-cycle slave wait.
    do_reset(); slave_mode = 2; slave_fixed = 3;
    @(negedge clk_100MHz);
    lsu_addr_i = 32'h20; lsu_we_i = 1; lsu_be_i = 4'b0011; lsu_wdata_i = 32'h1234_ABCD; lsu_req_i = 1;
    n_req = 0; got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      @(negedge clk_100MHz); #1;
      cyc++;
      if (m_req_o) begin
        n_req++;
        check("t5_we", 32'(m_we_o), 1); check("t5_be", 32'(m_be_o), 32'b0011);
        check("t5_addr", m_addr_o, 32'h20); check("t5_wdata", m_wdata_o, 32'h1234_ABCD);
      end
      got = lsu_ack_o;
    end
    lsu_req_i = 0;
    check("t5_ack", 32'(got), 1); check("t5_req_cycles", 32'(n_req), 4);
    check("t5_mem", slave_rd(32'h20), merge(init_val(32'h20), 32'h1234_ABCD, 4'b0011));

    // Reset during WAIT with a late slave ack.
    do_reset();
    @(negedge clk_100MHz);
    lsu_addr_i = 32'h200; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_req_i = 1;
    @(negedge clk_100MHz); #1;
    check("t6_in_wait", 32'(m_req_o), 1);
    arst_n = 0; lsu_req_i = 0;
    @(negedge clk_100MHz); #1;
    check("t6_rst_mreq", 32'(m_req_o), 0); check("t6_rst_ack", 32'(lsu_ack_o), 0);
    m_ack_i = 1; m_rdata_i = 32'h7777_7777; arst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_100MHz); #1;
      m_ack_i = 0;
      check("t6_no_ack", {29'd0, ifu_ack_o, lsu_ack_o, dbg_ack_o}, 0);
      check("t6_mreq_low", 32'(m_req_o), 0); check("t6_err_low", 32'(err_o), 0);
      check("t6_rdata", lsu_rdata_o, 0);
    end
    slave_mode = 2; slave_fixed = 0;
    lsu_req_i = 1;
    wait_ack(2, 10, cyc, got);
    lsu_req_i = 0;
    check("t6_restart_latency", 32'(cyc), 2);

    // Random traffic against the scoreboard.
    do_reset();
    @(negedge clk_100MHz);
    slave_mode = 1; mon_en = 1'b1;
    fork
      run_master(1, 40);
      run_master(2, 40);
      run_master(3, 40);
    join
    repeat (5) @(negedge clk_100MHz);
    mon_en = 1'b0;
    check("rand_pending", 32'(q_ifu.size() + q_lsu.size() + q_dbg.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
